// File: rtl/dccm_port_arb.sv
// DCCM port arbiter: one memory port shared by the LSU (priority) and the DMA slave,
// with a starvation override for DMA and one-cycle read-data return routed to the owner.
module dccm_port_arb #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 39,
  parameter int DMA_STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              lsu_freeze_dc3,
  input  logic              lsu_req,
  input  logic              lsu_we,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  output logic              lsu_gnt,
  output logic              lsu_rvalid,
  output logic [DATA_W-1:0] lsu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dccm_wren,
  output logic              dccm_rden,
  output logic [ADDR_W-1:0] dccm_wr_addr,
  output logic [ADDR_W-1:0] dccm_rd_addr_lo,
  output logic [ADDR_W-1:0] dccm_rd_addr_hi,
  output logic [DATA_W-1:0] dccm_wr_data,
  input  logic [DATA_W-1:0] dccm_rd_data_lo
);

  localparam int              CNT_W   = $clog2(DMA_STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DMA_STARVE_MAX);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_LSU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  owner_e            rd_owner_q, rd_owner_d;
  logic              lsu_pend_q, dma_pend_q;
  logic              lsu_win, dma_win, win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    lsu_win = 1'b0;
    dma_win = 1'b0;
    if (rst_l && !lsu_freeze_dc3) begin
      if (dma_req && (starve_cnt_q == CNT_MAX)) dma_win = 1'b1;
      else if (lsu_req)                         lsu_win = 1'b1;
      else if (dma_req)                         dma_win = 1'b1;
    end
  end

  always_comb begin
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    if (lsu_win) begin
      win_we    = lsu_we;
      win_addr  = lsu_addr;
      win_wdata = lsu_wdata;
    end else if (dma_win) begin
      win_we    = dma_we;
      win_addr  = dma_addr;
      win_wdata = dma_wdata;
    end
  end

  assign lsu_gnt         = lsu_win;
  assign dma_gnt         = dma_win;
  assign dccm_wren       = (lsu_win | dma_win) & win_we;
  assign dccm_rden       = (lsu_win | dma_win) & ~win_we;
  assign dccm_wr_addr    = win_addr;
  assign dccm_rd_addr_lo = win_addr;
  assign dccm_rd_addr_hi = win_addr;
  assign dccm_wr_data    = win_wdata;

  // The counter only ages while DMA is actually competing; a frozen cycle is not a lost one.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!dma_req || dma_win)                         starve_cnt_d = '0;
    else if (!lsu_freeze_dc3 && starve_cnt_q != CNT_MAX) starve_cnt_d = starve_cnt_q + CNT_W'(1);
  end

  always_comb begin
    rd_owner_d = OWN_NONE;
    if (lsu_win && !lsu_we)      rd_owner_d = OWN_LSU;
    else if (dma_win && !dma_we) rd_owner_d = OWN_DMA;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      starve_cnt_q <= '0;
      rd_owner_q   <= OWN_NONE;
      lsu_pend_q   <= 1'b0;
      dma_pend_q   <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rd_owner_q   <= rd_owner_d;
      lsu_pend_q   <= lsu_req & ~lsu_win;
      dma_pend_q   <= dma_req & ~dma_win;
    end
  end

  assign lsu_rvalid = (rd_owner_q == OWN_LSU);
  assign dma_rvalid = (rd_owner_q == OWN_DMA);
  assign lsu_rdata  = lsu_rvalid ? dccm_rd_data_lo : '0;
  assign dma_rdata  = dma_rvalid ? dccm_rd_data_lo : '0;

  // A request must stay up until it is granted.
  a_lsu_hold: assert property (@(posedge clk) disable iff (!rst_l) lsu_pend_q |-> lsu_req);
  a_dma_hold: assert property (@(posedge clk) disable iff (!rst_l) dma_pend_q |-> dma_req);
  a_one_gnt:  assert property (@(posedge clk) !(lsu_gnt && dma_gnt));

endmodule

// File: tb/tb_dccm_port_arb.sv
// Directed bench for dccm_port_arb: grants/DCCM drive checked per cycle, read returns
// checked by a monitor against a scoreboard of expected (owner, data) pairs.
module tb_dccm_port_arb;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        lsu_freeze_dc3, lsu_req, lsu_we, dma_req, dma_we;
  logic [15:0] lsu_addr, dma_addr;
  logic [38:0] lsu_wdata, dma_wdata;
  logic        lsu_gnt, lsu_rvalid, dma_gnt, dma_rvalid;
  logic [38:0] lsu_rdata, dma_rdata;
  logic        dccm_wren, dccm_rden;
  logic [15:0] dccm_wr_addr, dccm_rd_addr_lo, dccm_rd_addr_hi;
  logic [38:0] dccm_wr_data, dccm_rd_data_lo;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct { bit is_dma; logic [38:0] data; } ret_t;
  ret_t sb[$];

  logic [38:0] mem [0:255];

  always #5 clk = ~clk;

  dccm_port_arb dut (
    .clk(clk), .rst_l(rst_l), .lsu_freeze_dc3(lsu_freeze_dc3),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .dccm_wren(dccm_wren), .dccm_rden(dccm_rden), .dccm_wr_addr(dccm_wr_addr),
    .dccm_rd_addr_lo(dccm_rd_addr_lo), .dccm_rd_addr_hi(dccm_rd_addr_hi),
    .dccm_wr_data(dccm_wr_data), .dccm_rd_data_lo(dccm_rd_data_lo)
  );

  // Memory model: one-cycle read latency.
  always @(posedge clk) begin
    if (dccm_rden) dccm_rd_data_lo <= mem[dccm_rd_addr_lo[7:0]];
    if (dccm_wren) mem[dccm_wr_addr[7:0]] <= dccm_wr_data;
  end

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic lr, input logic lwe, input logic [15:0] la, input logic [38:0] lwd,
                       input logic dr, input logic dwe, input logic [15:0] da, input logic [38:0] dwd,
                       input logic frz);
    lsu_req = lr; lsu_we = lwe; lsu_addr = la; lsu_wdata = lwd;
    dma_req = dr; dma_we = dwe; dma_addr = da; dma_wdata = dwd;
    lsu_freeze_dc3 = frz;
  endtask

  // Checks the combinational grant/drive in the current cycle, then advances one cycle.
  task automatic step(input string name, input bit egl, input bit egd, input bit ewr, input bit erd,
                      input logic [15:0] eaddr, input logic [38:0] ewd, input logic [38:0] erdata,
                      input bit push);
    @(negedge clk);
    check({name, "_gnt"}, 80'({lsu_gnt, dma_gnt, dccm_wren, dccm_rden}), 80'({egl, egd, ewr, erd}));
    if (ewr) begin
      check({name, "_waddr"}, 80'(dccm_wr_addr), 80'(eaddr));
      check({name, "_wdata"}, 80'(dccm_wr_data), 80'(ewd));
    end else if (erd) begin
      check({name, "_raddr"}, 80'({dccm_rd_addr_lo, dccm_rd_addr_hi}), 80'({eaddr, eaddr}));
    end else begin
      check({name, "_idle"}, 80'({dccm_wr_addr, dccm_rd_addr_lo, dccm_wr_data}), 80'(0));
    end
    if (erd && push) sb.push_back('{egd, erdata});
    @(posedge clk); #1;
  endtask

  // Read-return monitor.
  initial begin
    ret_t e;
    forever begin
      @(negedge clk);
      if (lsu_rvalid || dma_rvalid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_rvalid: got lsu=%b dma=%b expected none", lsu_rvalid, dma_rvalid);
        end else begin
          e = sb.pop_front();
          check("ret_owner", 80'({lsu_rvalid, dma_rvalid}), e.is_dma ? 80'(2'b01) : 80'(2'b10));
          check("ret_data", e.is_dma ? 80'(dma_rdata) : 80'(lsu_rdata), 80'(e.data));
          check("ret_other_rdata", e.is_dma ? 80'(lsu_rdata) : 80'(dma_rdata), 80'(0));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h40] = 39'h55AA;
    mem[8'h44] = 39'h12_3456_789A;
    mem[8'h48] = 39'h4A_BCDE_F012;
    dccm_rd_data_lo = '0;

    // Reset: requests up, everything must stay 0.
    rst_l = 1'b0;
    drive(1, 0, 16'h40, 0, 1, 0, 16'h48, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", 80'({lsu_gnt, dma_gnt, dccm_wren, dccm_rden, lsu_rvalid, dma_rvalid}), 80'(0));
    check("rst_data", 80'({lsu_rdata, dma_rdata}), 80'(0));
    check("rst_addr", 80'({dccm_wr_addr, dccm_rd_addr_lo, dccm_rd_addr_hi}), 80'(0));
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_l = 1'b1;
    @(posedge clk); #1;

    // 1. LSU read of 0x0040 returns 0x55AA next cycle.
    drive(1, 0, 16'h40, 0, 0, 0, 0, 0, 0);
    step("t1_rd", 1, 0, 0, 1, 16'h40, 0, 39'h55AA, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("t1_idle", 0, 0, 0, 0, 0, 0, 0, 0);
    check("t1_sb_drained", 80'(sb.size()), 80'(0));

    // 2. Starvation: both write continuously; DMA wins every 5th cycle.
    drive(1, 1, 16'h60, 39'h1, 1, 1, 16'h70, 39'h2, 0);
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4) step($sformatf("t2_c%0d", i), 0, 1, 1, 0, 16'h70, 39'h2, 0, 0);
      else            step($sformatf("t2_c%0d", i), 1, 0, 1, 0, 16'h60, 39'h1, 0, 0);
    end

    // 3. LSU read then freeze for 3 cycles; read still returns, counter holds at 1.
    drive(1, 0, 16'h44, 0, 1, 1, 16'h70, 39'h2, 0);
    step("t3_rd", 1, 0, 0, 1, 16'h44, 0, 39'h12_3456_789A, 1);
    drive(1, 1, 16'h60, 39'h1, 1, 1, 16'h70, 39'h2, 1);
    for (int i = 0; i < 3; i++) step($sformatf("t3_frz%0d", i), 0, 0, 0, 0, 0, 0, 0, 0);
    check("t3_sb_drained", 80'(sb.size()), 80'(0));
    drive(1, 1, 16'h60, 39'h1, 1, 1, 16'h70, 39'h2, 0);
    for (int i = 0; i < 3; i++) step($sformatf("t3_lsu%0d", i), 1, 0, 1, 0, 16'h60, 39'h1, 0, 0);
    step("t3_dma", 0, 1, 1, 0, 16'h70, 39'h2, 0, 0);

    // 4. Back-to-back: LSU read A, DMA read B, LSU write C.
    drive(1, 0, 16'h40, 0, 0, 0, 0, 0, 0);
    step("t4_a", 1, 0, 0, 1, 16'h40, 0, 39'h55AA, 1);
    drive(0, 0, 0, 0, 1, 0, 16'h48, 0, 0);
    step("t4_b", 0, 1, 0, 1, 16'h48, 0, 39'h4A_BCDE_F012, 1);
    drive(1, 1, 16'h50, 39'h33, 0, 0, 0, 0, 0);
    step("t4_c", 1, 0, 1, 0, 16'h50, 39'h33, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("t4_idle", 0, 0, 0, 0, 0, 0, 0, 0);
    check("t4_sb_drained", 80'(sb.size()), 80'(0));

    // 5. Reset the cycle after a DMA read grant: the return is dropped.
    drive(0, 0, 0, 0, 1, 0, 16'h48, 0, 0);
    step("t5_rd", 0, 1, 0, 1, 16'h48, 0, 0, 0);
    rst_l = 1'b0;
    drive(1, 0, 16'h40, 0, 1, 0, 16'h48, 0, 0);
    #1;
    check("t5_rst_rvalid", 80'({lsu_rvalid, dma_rvalid}), 80'(0));
    check("t5_rst_rdata", 80'({lsu_rdata, dma_rdata}), 80'(0));
    step("t5_rst_hold", 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_l = 1'b1;
    for (int i = 0; i < 3; i++) step($sformatf("t5_post%0d", i), 0, 0, 0, 0, 0, 0, 0, 0);
    check("t5_no_rvalid", 80'({lsu_rvalid, dma_rvalid}), 80'(0));
    check("end_sb_drained", 80'(sb.size()), 80'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
